// File: rtl/m_dm_bytelane.sv
// Byte-lane data memory for the M stage: LW/LH/LHU/LB/LBU/SW/SH/SB with wait states,
// self-clear after reset and alignment/range checks. Define DM_TRACE_EN to print committed stores.
//
// state   | meaning
// CLEAR   | zeroing the array one word per cycle, ready=0
// IDLE    | ready=1, waiting for req
// BUSY    | wait counter running; access commits when it reaches 0
// DONE    | one-cycle response: done=1, rdata/err valid
module m_dm_bytelane #(
  parameter int DEPTH = 3072,
  parameter int LAT   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state, state_d;
  logic [AW-1:0] clr_cnt;
  logic [2:0]  wait_cnt;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, pc_q;

  logic [31:0] mem [0:DEPTH-1];

  logic [AW-1:0] idx;
  logic [31:0] rd_word, wr_word, load_val, lane_b_word;
  logic [15:0] lane_h;
  logic [7:0]  lane_b;
  logic        is_store, mis_err, range_err, acc_err, commit;
  logic        ready_d, done_d, err_d, mem_we;
  logic [31:0] rdata_d;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_CLEAR;
    else        state <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state;
    case (state)
      S_CLEAR: if (clr_cnt == AW'(DEPTH - 1)) state_d = S_IDLE;
      S_IDLE:  if (req) state_d = S_BUSY;
      S_BUSY:  if (wait_cnt == 3'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase
  end

  // ---------------- access datapath ----------------
  assign idx       = addr_q[AW+1:2];
  assign rd_word   = mem[idx];
  assign is_store  = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);
  assign range_err = ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign acc_err   = mis_err || range_err;
  assign commit    = (state == S_BUSY) && (wait_cnt == 3'd0);

  always_comb begin
    mis_err = 1'b0;
    case (op_q)
      OP_LW, OP_SW:         mis_err = (addr_q[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: mis_err = addr_q[0];
      default:              mis_err = 1'b0;
    endcase
  end

  assign lane_b_word = rd_word >> {addr_q[1:0], 3'b000};
  assign lane_b      = lane_b_word[7:0];
  assign lane_h      = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    case (op_q)
      OP_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_val = {16'h0000, lane_h};
      OP_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_val = {24'h000000, lane_b};
      default: load_val = rd_word;
    endcase
  end

  // Read-modify-write merge: only the addressed lanes take new data.
  always_comb begin
    wr_word = rd_word;
    case (op_q)
      OP_SW: wr_word = wdata_q;
      OP_SH: wr_word = addr_q[1] ? {wdata_q[15:0], rd_word[15:0]}
                                 : {rd_word[31:16], wdata_q[15:0]};
      OP_SB: begin
        case (addr_q[1:0])
          2'd0:    wr_word = {rd_word[31:8], wdata_q[7:0]};
          2'd1:    wr_word = {rd_word[31:16], wdata_q[7:0], rd_word[7:0]};
          2'd2:    wr_word = {rd_word[31:24], wdata_q[7:0], rd_word[15:0]};
          default: wr_word = {wdata_q[7:0], rd_word[23:0]};
        endcase
      end
      default: wr_word = rd_word;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
    err_d   = 1'b0;
    rdata_d = 32'h0;
    mem_we  = 1'b0;
    if (commit) begin
      err_d   = acc_err;
      rdata_d = (acc_err || is_store) ? 32'h0 : load_val;
      mem_we  = is_store && !acc_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      ready <= ready_d;
      done  <= done_d;
      err   <= err_d;
      rdata <= rdata_d;
    end
  end

  // ---------------- request latch and counters ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clr_cnt  <= '0;
      wait_cnt <= 3'd0;
      op_q     <= 3'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      pc_q     <= 32'h0;
    end else begin
      if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (state == S_IDLE && req) begin
        op_q     <= op;
        addr_q   <= addr;
        wdata_q  <= wdata;
        pc_q     <= pc;
        wait_cnt <= 3'(LAT);
      end else if (state == S_BUSY && wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

  // Array has no reset; gating on reset keeps an aborted store from landing.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == S_CLEAR) begin
        mem[clr_cnt] <= 32'h0;
      end else if (mem_we) begin
        mem[idx] <= wr_word;
`ifdef DM_TRACE_EN
        $display("@%08h: *%08h <= %08h", pc_q, {addr_q[31:2], 2'b00}, wr_word);
`endif
      end
    end
  end

`ifndef DM_TRACE_EN
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

endmodule

// File: doc/m_dm_bytelane.md
# m_dm_bytelane

Parametrised data memory for the MIPS pipeline's M stage. It adds byte and halfword access (lb/lbu/lh/lhu/sb/sh alongside lw/sw), a req/ready/done handshake with configurable wait states, and alignment and range error detection. After every reset it runs a self-clear sequence that zeroes the array one word per cycle. It sits between the M-stage pipeline register and W-stage writeback; the pipeline stalls while `ready` is low or a response is outstanding.

## Interface
Parameters:
- `DEPTH`, 3072: number of 32-bit words; legal byte addresses are 0 to 4*DEPTH-1.
- `LAT`, 0: extra wait cycles per access, range 0–7.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `req`  in  1  — access request; sampled only while `ready`=1.
- `op`  in  3  — 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- `addr`  in  32  — byte address.
- `wdata`  in  32  — store data; the low byte or halfword is used for SB/SH.
- `pc`  in  32  — PC of the requesting instruction; used for the trace only.
- `ready`  out  1  — block can accept a request this cycle.
- `done`  out  1  — one-cycle pulse; `rdata` and `err` are valid.
- `rdata`  out  32  — extended load result; 0 for stores and on error.
- `err`  out  1  — access was misaligned or out of range.

## Operation
- The FSM has four states: CLEAR, IDLE, BUSY, DONE.
- CLEAR:
  - Entered asynchronously while `reset`=0.
  - After release, a counter writes 0 to word 0 through DEPTH-1, one word per cycle.
  - Moves to IDLE on the edge that writes word DEPTH-1.
  - `ready`=0 throughout; `req` is ignored.
- IDLE:
  - `ready`=1.
  - On an edge with `req`=1, latch `op`, `addr`, `wdata` and `pc`, load the wait counter with LAT, and go to BUSY.
- BUSY:
  - `ready`=0.
  - If the counter is non-zero, decrement it.
  - If the counter is 0, perform the access on this edge and go to DONE.
- DONE:
  - `done`=1 for exactly one cycle, then go to IDLE.
- Error checks, using the latched address:
  - Misaligned: LW or SW with `addr[1:0]`≠0, or LH, LHU or SH with `addr[0]`≠0.
  - Out of range: `addr[31:2]` ≥ DEPTH.
  - On error: `err`=1, `rdata`=0, and the array is not modified.
- Loads read word `addr[31:2]` and select a lane with `addr[1:0]`:
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Byte lane k is bits 8k+7 to 8k (little-endian).
- Stores do a read-modify-write of the addressed word:
  - Only the byte lanes selected by `addr[1:0]` change.
  - SB writes `wdata[7:0]`; SH writes `wdata[15:0]`.
- Reset during BUSY or DONE aborts the access. A store that had not yet reached its commit edge is discarded, and CLEAR restarts from word 0.
- Array contents are never read by CLEAR, so the memory's power-up value is irrelevant.

## Timing
- Reset values: `ready`=0, `done`=0, `err`=0, `rdata`=0. These hold until the end of CLEAR and are all registered outputs.
- Clear duration: `ready` rises DEPTH cycles after `reset` deasserts.
- Access latency: a request accepted at edge E0 commits at edge E0+LAT+1. `done`, `rdata` and `err` are high/valid in the cycle after that edge.
- Outside the DONE cycle, `rdata` and `err` read 0.
- Throughput: at most one access per LAT+3 cycles. The next request can be accepted at the edge that ends DONE+1, i.e. in IDLE.
- Read-after-write: a load issued after a store's `done` sees the stored data. There is no overlap, so no forwarding is needed.
- `req` held high across BUSY/DONE is not a new request until IDLE samples it again.

## Configuration
- `DM_TRACE_EN` defined:
  - On every committed, non-error store, print `@<pc>: *<word-aligned addr> <= <merged 32-bit word>` with $display. Fields are 8-digit hex.
  - The print occurs on the commit edge.
- Undefined: no simulation output.
- Functional behaviour is identical either way.

## Test plan
- Reset release with DEPTH=16 → `ready` stays 0 for 16 cycles, then 1. A following LW of 0x3C returns 0 with `err`=0.
- SW 0x11223344 to 0x40, then SB 0xAB to 0x41 → LW 0x40 returns 0x1122AB44. LB 0x41 returns 0xFFFFFFAB; LBU 0x41 returns 0x000000AB.
- SH 0x8001 to 0x46 → LH 0x46 returns 0xFFFF8001 and LHU 0x46 returns 0x00008001. With LAT=3, `done` arrives 5 cycles after acceptance.
- LW 0x42 and SH 0x43 → `err`=1, `rdata`=0, and word 0x40 is unchanged. SW to 4*DEPTH → `err`=1.
- Reset pulse while a LAT=5 SW is in BUSY → the store is lost. After the re-clear, LW of that address returns 0 and no trace line was printed.
- Back-to-back requests with `req` held high → accepts are spaced exactly LAT+3 cycles apart, and one `done` pulse is produced per accept.
